// File: rtl/vga_rx.sv
// rtl/vga_rx.sv - VGA receiver: sync tracking, lock detection, pixel coordinates and colour reduction
//
// Optional feature macro: VGA_RX_CHECKSUM_EN (per-frame pixel checksum on frame_sum).
//
// Ports:
//   vgaclk            in   pixel clock
//   rst               in   synchronous, active-high reset
//   hsync, vsync      in   active-low syncs
//   red, green, blue  in   4-bit colour components
//   px_x, px_y        out  active pixel coordinate (0 when px_valid is 0)
//   px_valid          out  locked and inside the active window
//   px_red, px_green  out  3-bit reduced colour
//   px_blue           out  2-bit reduced colour
//   frame_start       out  one-cycle pulse per vsync rise
//   locked            out  timing lock status
//   timing_err        out  one-cycle pulse on a line or frame timing violation
//   frame_sum         out  per-frame checksum (0 without VGA_RX_CHECKSUM_EN)
//   frame_sum_valid   out  one-cycle pulse when frame_sum updates
module vga_rx #(
    parameter int HPIXELS     = 640,
    parameter int HBP         = 48,
    parameter int VPIXELS     = 480,
    parameter int VBP         = 33,
    parameter int HTOTAL      = 800,
    parameter int HTOL        = 2,
    parameter int VTOTAL      = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        vgaclk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic        px_valid,
    output logic [2:0]  px_red,
    output logic [2:0]  px_green,
    output logic [1:0]  px_blue,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err,
    output logic [15:0] frame_sum,
    output logic        frame_sum_valid
);

    localparam logic [1:0] ST_ACQUIRE = 2'd0;
    localparam logic [1:0] ST_TRACK   = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [9:0]  HBP_W   = 10'(HBP);
    localparam logic [9:0]  H_END   = 10'(HBP + HPIXELS);
    localparam logic [9:0]  VBP_W   = 10'(VBP);
    localparam logic [9:0]  V_END   = 10'(VBP + VPIXELS);
    localparam logic [10:0] LEN_MIN = 11'(HTOTAL - HTOL);
    localparam logic [10:0] LEN_MAX = 11'(HTOTAL + HTOL);
    localparam logic [10:0] VTOT_W  = 11'(VTOTAL);
    localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

    logic       hs_s1, hs_s2, vs_s1, vs_s2;
    logic [2:0] r_s1, g_s1;
    logic [1:0] b_s1;
    logic       primed, h_arm, v_arm, h_seen, frame_err;
    logic [9:0] h_q, v_q;
    logic [1:0] state;
    logic [7:0] good_cnt;

    logic        h_rise, v_rise, line_bad, frame_bad, err_now, frame_ok, pix_on;
    logic [9:0]  h_inc, v_inc, h_cur, v_cur;
    logic [10:0] line_len, frame_cnt;
    logic [7:0]  good_nxt;

    // Low colour bits are dropped by the reduction.
    logic unused_colour;
    assign unused_colour = ^{red[0], green[0], blue[1:0]};

    // The sync stages come out of reset low, which looks like an asserted
    // sync. A rise only counts once a real low has been sampled, so a reset
    // released mid-line or mid-frame cannot fake an edge.
    assign h_rise = hs_s1 & ~hs_s2 & h_arm;
    assign v_rise = vs_s1 & ~vs_s2 & v_arm;

    assign h_inc = (h_q == 10'h3FF) ? h_q : h_q + 10'd1;
    assign v_inc = (v_q == 10'h3FF) ? v_q : v_q + 10'd1;
    assign h_cur = h_rise ? 10'd0 : h_inc;
    assign v_cur = v_rise ? 10'd0 : (h_rise ? v_inc : v_q);

    // h_q holds the count of the previous cycle, so the line just ended is h_q+1 clocks.
    assign line_len = {1'b0, h_q} + 11'd1;
    assign line_bad = h_rise & h_seen & ((line_len < LEN_MIN) | (line_len > LEN_MAX));

    // An hsync rise coincident with the vsync rise still belongs to the frame that ends.
    assign frame_cnt = {1'b0, v_q} + {10'd0, h_rise};
    assign frame_bad = v_rise & (state != ST_ACQUIRE) & (frame_cnt != VTOT_W);

    assign err_now  = line_bad | frame_bad;
    assign frame_ok = ~frame_err & ~err_now;
    assign good_nxt = good_cnt + 8'd1;

    assign pix_on = locked & (h_cur >= HBP_W) & (h_cur < H_END) & (v_cur >= VBP_W) & (v_cur < V_END);

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            hs_s1       <= 1'b0;
            hs_s2       <= 1'b0;
            vs_s1       <= 1'b0;
            vs_s2       <= 1'b0;
            r_s1        <= 3'd0;
            g_s1        <= 3'd0;
            b_s1        <= 2'd0;
            primed      <= 1'b0;
            h_arm       <= 1'b0;
            v_arm       <= 1'b0;
            h_seen      <= 1'b0;
            frame_err   <= 1'b0;
            h_q         <= 10'd0;
            v_q         <= 10'd0;
            state       <= ST_ACQUIRE;
            good_cnt    <= 8'd0;
            timing_err  <= 1'b0;
            frame_start <= 1'b0;
            px_valid    <= 1'b0;
            px_x        <= 10'd0;
            px_y        <= 10'd0;
            px_red      <= 3'd0;
            px_green    <= 3'd0;
            px_blue     <= 2'd0;
        end else begin
            hs_s1  <= hsync;
            hs_s2  <= hs_s1;
            vs_s1  <= vsync;
            vs_s2  <= vs_s1;
            r_s1   <= red[3:1];
            g_s1   <= green[3:1];
            b_s1   <= blue[3:2];
            primed <= 1'b1;
            h_arm  <= h_arm | (primed & ~hs_s1);
            v_arm  <= v_arm | (primed & ~vs_s1);
            h_seen <= h_seen | h_rise;
            h_q    <= h_cur;
            v_q    <= v_cur;

            timing_err  <= err_now;
            frame_start <= v_rise;
            frame_err   <= v_rise ? 1'b0 : (frame_err | err_now);

            px_valid <= pix_on;
            px_x     <= pix_on ? h_cur - HBP_W : 10'd0;
            px_y     <= pix_on ? v_cur - VBP_W : 10'd0;
            px_red   <= pix_on ? r_s1 : 3'd0;
            px_green <= pix_on ? g_s1 : 3'd0;
            px_blue  <= pix_on ? b_s1 : 2'd0;

            // Lock reacts to the registered timing_err, so locked drops the
            // cycle after the error pulse.
            case (state)
                ST_ACQUIRE: begin
                    if (v_rise) begin
                        state    <= ST_TRACK;
                        good_cnt <= 8'd0;
                    end
                end
                ST_TRACK: begin
                    if (v_rise && frame_ok) begin
                        good_cnt <= good_nxt;
                        if (good_nxt >= LOCK_N) begin
                            state <= ST_LOCKED;
                        end
                    end else if (v_rise || timing_err) begin
                        good_cnt <= 8'd0;
                    end
                end
                ST_LOCKED: begin
                    if (timing_err) begin
                        state    <= ST_TRACK;
                        good_cnt <= 8'd0;
                    end
                end
                default: begin
                    state    <= ST_ACQUIRE;
                    good_cnt <= 8'd0;
                end
            endcase
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] acc, sum_next;

    assign sum_next = acc + (px_valid ? {8'd0, px_red, px_green, px_blue} : 16'd0);

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            acc             <= 16'd0;
            frame_sum       <= 16'd0;
            frame_sum_valid <= 1'b0;
        end else begin
            frame_sum_valid <= 1'b0;
            if (v_rise) begin
                acc <= 16'd0;
                if (locked) begin
                    frame_sum       <= sum_next;
                    frame_sum_valid <= 1'b1;
                end
            end else begin
                acc <= sum_next;
            end
        end
    end
`else
    assign frame_sum       = 16'd0;
    assign frame_sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx.sv
// tb/tb_vga_rx.sv - directed self-checking bench for vga_rx on a scaled-down 20x10 timing
module tb_vga_rx;

    localparam int HPIXELS     = 8;
    localparam int HBP         = 4;
    localparam int VPIXELS     = 4;
    localparam int VBP         = 2;
    localparam int HTOTAL      = 20;
    localparam int HTOL        = 2;
    localparam int VTOTAL      = 10;
    localparam int LOCK_FRAMES = 2;

`ifdef VGA_RX_CHECKSUM_EN
    localparam int          EXP_FSV = 1;
    localparam logic [15:0] EXP_SUM = 16'h0020;
`else
    localparam int          EXP_FSV = 0;
    localparam logic [15:0] EXP_SUM = 16'h0000;
`endif

    logic        vgaclk = 1'b0;
    logic        rst    = 1'b1;
    logic        hsync  = 1'b0;
    logic        vsync  = 1'b0;
    logic [3:0]  red    = 4'd0;
    logic [3:0]  green  = 4'd0;
    logic [3:0]  blue   = 4'd0;
    logic [9:0]  px_x, px_y;
    logic        px_valid;
    logic [2:0]  px_red, px_green;
    logic [1:0]  px_blue;
    logic        frame_start, locked, timing_err, frame_sum_valid;
    logic [15:0] frame_sum;
    logic [48:0] all_outs;

    always #5 vgaclk = ~vgaclk;

    vga_rx #(
        .HPIXELS(HPIXELS), .HBP(HBP), .VPIXELS(VPIXELS), .VBP(VBP),
        .HTOTAL(HTOTAL), .HTOL(HTOL), .VTOTAL(VTOTAL), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .vgaclk(vgaclk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
        .px_red(px_red), .px_green(px_green), .px_blue(px_blue),
        .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
        .frame_sum(frame_sum), .frame_sum_valid(frame_sum_valid)
    );

    assign all_outs = {px_x, px_y, px_valid, px_red, px_green, px_blue, frame_start,
                       locked, timing_err, frame_sum, frame_sum_valid};

    int n_checks = 0;
    int n_errors = 0;

    int   n_fs = 0, n_terr = 0, n_fsv = 0, n_unlocked = 0;
    int   lock_rise_at = -1;
    logic lock_rise_fs = 1'b0, fall_after_terr = 1'b0;
    logic prev_locked = 1'b0, prev_terr = 1'b0;
    int   cur_ln = -1, cur_h = -1, o_ln = -1, o_h = -1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one input cycle; afterwards the px outputs belong to the input of the previous call.
    task automatic step(input logic hs, input logic vs, input logic [3:0] r, input logic [3:0] g,
                        input logic [3:0] b, input int ln, input int h);
        hsync = hs;
        vsync = vs;
        red   = r;
        green = g;
        blue  = b;
        @(posedge vgaclk);
        #1;
        o_ln   = cur_ln;
        o_h    = cur_h;
        cur_ln = ln;
        cur_h  = h;
        if (frame_start) n_fs++;
        if (timing_err) n_terr++;
        if (frame_sum_valid) n_fsv++;
        if (!locked) n_unlocked++;
        if (!prev_locked && locked) begin
            lock_rise_at = n_fs;
            lock_rise_fs = frame_start;
        end
        if (prev_locked && !locked) fall_after_terr = prev_terr;
        prev_locked = locked;
        prev_terr   = timing_err;
    endtask

    task automatic pixel_checks();
        if (o_ln == VBP && o_h == HBP - 1)
            check_eq("px_before_first", 64'({px_valid, px_x, px_red}), 64'd0);
        if (o_ln == VBP && o_h == HBP)
            check_eq("px_first", 64'({px_valid, px_x, px_y, px_red}), 64'({1'b1, 10'd0, 10'd0, 3'h7}));
        if (o_ln == VBP && o_h == HBP + HPIXELS - 1)
            check_eq("px_last_x", 64'({px_valid, px_x, px_y}), 64'({1'b1, 10'd7, 10'd0}));
        if (o_ln == VBP && o_h == HBP + HPIXELS)
            check_eq("px_after_x", 64'({px_valid, px_x, px_red}), 64'd0);
        if (o_ln == VBP + VPIXELS - 1 && o_h == HBP)
            check_eq("px_last_y", 64'({px_valid, px_x, px_y}), 64'({1'b1, 10'd0, 10'd3}));
        if (o_ln == VBP + VPIXELS && o_h == HBP)
            check_eq("px_after_y", 64'({px_valid, px_y, px_red}), 64'd0);
    endtask

    // One frame: sync low for the last 4 clocks of each line, vsync low for the last 2 lines.
    task automatic run_frame(input int len_all, input int long_ln, input int long_len,
                             input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                             input bit do_px, input int rst_ln);
        for (int ln = 0; ln < VTOTAL; ln++) begin
            int len;
            len = (ln == long_ln) ? long_len : len_all;
            for (int h = 0; h < len; h++) begin
                if (ln == rst_ln && h == 5) rst = 1'b1;
                step(h < len - 4, ln < VTOTAL - 2, r, g, b, ln, h);
                if (rst) begin
                    rst = 1'b0;
                    check_eq("midframe_reset_outputs", 64'(all_outs), 64'd0);
                end
                if (do_px) pixel_checks();
            end
        end
    endtask

    initial begin
        int base_terr, base_unl, base_fsv, base_fs;

        for (int i = 0; i < 3; i++)
            step(i[0], ~i[0], 4'(5 * i + 3), 4'(i + 9), 4'(12 - i), -1, -1);
        check_eq("reset_outputs", 64'(all_outs), 64'd0);
        check_eq("reset_fsm_acquire", 64'(dut.state), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, -1, -1);

        run_frame(HTOTAL, -1, 0, 4'h0, 4'h0, 4'h0, 1'b0, -1);
        run_frame(HTOTAL, -1, 0, 4'h0, 4'h0, 4'h0, 1'b0, -1);
        run_frame(HTOTAL, -1, 0, 4'hE, 4'h0, 4'h0, 1'b1, -1);
        check_eq("lock_on_3rd_vsync", 64'(lock_rise_at), 64'd3);
        check_eq("lock_with_frame_start", 64'(lock_rise_fs), 64'd1);
        check_eq("no_err_nominal", 64'(n_terr), 64'd0);

        base_terr = n_terr;
        run_frame(HTOTAL, 4, HTOTAL + 10, 4'h0, 4'h0, 4'h0, 1'b0, -1);
        check_eq("long_line_err_once", 64'(n_terr - base_terr), 64'd1);
        check_eq("unlock_after_err", 64'(fall_after_terr), 64'd1);
        check_eq("unlocked_after_long", 64'(locked), 64'd0);
        run_frame(HTOTAL, -1, 0, 4'h0, 4'h0, 4'h0, 1'b0, -1);
        run_frame(HTOTAL, -1, 0, 4'h0, 4'h0, 4'h0, 1'b0, -1);
        run_frame(HTOTAL, -1, 0, 4'h0, 4'h0, 4'h0, 1'b0, -1);
        check_eq("relock_after_2_good", 64'(lock_rise_at), 64'd7);
        check_eq("long_line_err_total", 64'(n_terr - base_terr), 64'd1);

        base_terr = n_terr;
        base_unl  = n_unlocked;
        run_frame(HTOTAL + 1, -1, 0, 4'h0, 4'h0, 4'h0, 1'b0, -1);
        run_frame(HTOTAL + HTOL, -1, 0, 4'h0, 4'h0, 4'h0, 1'b0, -1);
        run_frame(HTOTAL - HTOL, -1, 0, 4'h0, 4'h0, 4'h0, 1'b0, -1);
        check_eq("tolerance_no_err", 64'(n_terr - base_terr), 64'd0);
        check_eq("tolerance_stays_locked", 64'(n_unlocked - base_unl), 64'd0);

        run_frame(HTOTAL, -1, 0, 4'h0, 4'h0, 4'h4, 1'b0, -1);
        base_fsv = n_fsv;
        run_frame(HTOTAL, -1, 0, 4'h0, 4'h0, 4'h0, 1'b0, -1);
        check_eq("checksum_pulses", 64'(n_fsv - base_fsv), 64'(EXP_FSV));
        check_eq("checksum_value", 64'(frame_sum), 64'(EXP_SUM));

        base_terr = n_terr;
        run_frame(HTOTAL, -1, 0, 4'h0, 4'h0, 4'h0, 1'b0, 3);
        base_fs  = n_fs;
        base_fsv = n_fsv;
        check_eq("midframe_unlocked", 64'(locked), 64'd0);
        run_frame(HTOTAL, -1, 0, 4'h0, 4'h0, 4'h0, 1'b0, -1);
        run_frame(HTOTAL, -1, 0, 4'h0, 4'h0, 4'h0, 1'b0, -1);
        run_frame(HTOTAL, -1, 0, 4'h0, 4'h0, 4'h0, 1'b0, -1);
        check_eq("midframe_relock_3_rises", 64'(lock_rise_at - base_fs), 64'd3);
        check_eq("midframe_no_err", 64'(n_terr - base_terr), 64'd0);
        check_eq("midframe_no_sum", 64'(n_fsv - base_fsv), 64'd0);
        check_eq("frame_start_total", 64'(n_fs), 64'd16);
        check_eq("locked_at_end", 64'(locked), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_rx.md
VGA_RX -- requirements
Module: vga_rx

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  HPIXELS, 640, active pixels per line
  HBP, 48, clocks from hsync rising edge to first active pixel
  VPIXELS, 480, active lines per frame
  VBP, 33, lines from vsync rising edge to first active line
  HTOTAL, 800, nominal clocks per line
  HTOL, 2, allowed line-length deviation, in clocks
  VTOTAL, 525, required lines per frame
  LOCK_FRAMES, 2, consecutive good frames needed to lock
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  vgaclk  in  1  pixel clock, 25 MHz
  rst  in  1  reset, synchronous, active-high
  hsync, vsync  in  1 each  active-low syncs
  red, green, blue  in  4 each  incoming 12-bit colour
  px_x, px_y  out  10 each  active pixel coordinate
  px_valid  out  1  coordinate and colour are valid
  px_red, px_green  out  3 each  reduced colour
  px_blue  out  2  reduced colour
  frame_start  out  1  one-cycle pulse on every vsync rising edge
  locked  out  1  timing lock status
  timing_err  out  1  one-cycle pulse on a timing violation
  frame_sum  out  16  per-frame checksum (see Configuration)
  frame_sum_valid  out  1  one-cycle pulse when frame_sum updates

Function
REQ-003 All inputs SHALL be registered once (stage s1), then again (stage s2); edges SHALL be detected as s1 differing from s2.
REQ-004 h_cnt SHALL be 0 in the cycle a hsync rise is detected and increment by 1 each cycle after that, saturating at 1023.
REQ-005 v_cnt SHALL become 0 on a vsync rise and increment on each hsync rise, saturating at 1023; if both rises occur together, the vsync rise SHALL take precedence (v_cnt = 0).
REQ-006 A pixel SHALL be active when HBP <= h_cnt < HBP+HPIXELS and VBP <= v_cnt < VBP+VPIXELS; px_x = h_cnt-HBP and px_y = v_cnt-VBP.
REQ-007 Colour reduction SHALL be px_red = red[3:1], px_green = green[3:1], px_blue = blue[3:2].
REQ-008 Latency SHALL be 2 cycles: a pixel on the inputs at cycle N appears on the px_* outputs at cycle N+2; outputs are registered.
REQ-009 px_valid SHALL equal (locked AND active); when px_valid is 0, px_x, px_y and the px_* colour outputs SHALL be 0.
REQ-010 Line check: the clock count between consecutive hsync rises outside [HTOTAL-HTOL, HTOTAL+HTOL] SHALL pulse timing_err; the first rise after reset is not checked.
REQ-011 Frame check: an hsync-rise count between consecutive vsync rises other than VTOTAL SHALL pulse timing_err.
REQ-012 Lock FSM states:
  ACQUIRE: the reset state; moves to TRACK on the first vsync rise.
  TRACK: good_cnt increments on each vsync rise that ends an error-free frame; any timing_err clears good_cnt; on reaching LOCK_FRAMES, moves to LOCKED.
  LOCKED: any timing_err moves to TRACK with good_cnt = 0.
REQ-013 locked SHALL be 1 only in LOCKED, asserting the cycle after the qualifying vsync rise and deasserting the cycle after timing_err.

Reset
REQ-014 While rst is high, all outputs, counters, the FSM (ACQUIRE), good_cnt and the input stages SHALL clear to 0 on the next vgaclk edge.
REQ-015 Asserting rst mid-frame SHALL abort the frame; no frame_sum_valid or timing_err pulse SHALL be produced for it.

Configuration
REQ-016 With VGA_RX_CHECKSUM_EN defined, the block SHALL accumulate a mod-2^16 sum of {px_red, px_green, px_blue} over every px_valid cycle.
  On each vsync rise while LOCKED, it SHALL latch that sum into frame_sum, pulse frame_sum_valid and clear the accumulator.
REQ-017 Without VGA_RX_CHECKSUM_EN, the ports SHALL remain and frame_sum and frame_sum_valid SHALL be constant 0.

Verification
REQ-018 Reset: rst high for 3 cycles with toggling inputs -> all outputs 0 and the FSM in ACQUIRE.
REQ-019 Lock and pixel: nominal 800x525 timing -> locked rises 1 cycle after the 3rd vsync rise; red=4'hE at x=0, y=0 -> px_red=3'h7, px_x=0, px_y=0, px_valid=1 exactly 2 cycles later.
REQ-020 Long line: one 810-clock line while locked -> timing_err pulses once, locked drops, and relock requires 2 good frames.
REQ-021 Tolerance: every line 801 clocks -> no timing_err and locked stays 1.
REQ-022 Mid-frame reset: rst at v_cnt=200 -> outputs 0 the next cycle, and locked returns only after 3 further vsync rises.
REQ-023 Checksum (VGA_RX_CHECKSUM_EN): constant blue=4'b0100 with red and green 0 over a full locked frame -> frame_sum = 16'hB000 and frame_sum_valid pulses once.
